// File: rtl/alu_arbiter_if.sv
// Command/response bundle between two ALU requesters, the arbiter and the response consumer.
interface alu_arbiter_if #(parameter int WIDTH = 4);
   logic             req0_valid;
   logic             req0_ready;
   logic [WIDTH-1:0] req0_a;
   logic [WIDTH-1:0] req0_b;
   logic [2:0]       req0_op;
   logic             req1_valid;
   logic             req1_ready;
   logic [WIDTH-1:0] req1_a;
   logic [WIDTH-1:0] req1_b;
   logic [2:0]       req1_op;
   logic             rsp_valid;
   logic             rsp_ready;
   logic             rsp_id;
   logic [WIDTH-1:0] rsp_result;
   logic             rsp_zero;
   logic             rsp_err;

   modport master (
      output req0_valid, req0_a, req0_b, req0_op,
      output req1_valid, req1_a, req1_b, req1_op,
      output rsp_ready,
      input  req0_ready, req1_ready,
      input  rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err
   );

   modport slave (
      input  req0_valid, req0_a, req0_b, req0_op,
      input  req1_valid, req1_a, req1_b, req1_op,
      input  rsp_ready,
      output req0_ready, req1_ready,
      output rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err
   );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of a small ALU; one command in flight,
// response held until the consumer takes it.
module alu_arbiter #(
   parameter int WIDTH = 4
) (
   input logic          clk,
   input logic          rst,
   alu_arbiter_if.slave bus
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t           state;
   logic             last_grant;
   logic             any_valid;
   logic             grant;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [2:0]       op_q;
   logic             id_q;
   logic [WIDTH-1:0] result_q;
   logic             zero_q;
   logic             err_q;
   logic             valid_q;
   logic [WIDTH-1:0] alu_result;
   logic             alu_err;

   // On a tie the requester not served last wins; a lone requester always wins.
   always_comb begin
      any_valid = bus.req0_valid | bus.req1_valid;
      grant     = (bus.req0_valid && bus.req1_valid) ? ~last_grant : bus.req1_valid;
   end

   assign bus.req0_ready = (state == IDLE) && !rst && bus.req0_valid && !grant;
   assign bus.req1_ready = (state == IDLE) && !rst && bus.req1_valid && grant;

   always_comb begin
      alu_result = '0;
      alu_err    = 1'b0;
      case (op_q)
         3'b000:  alu_result = a_q + b_q;
         3'b001:  alu_result = a_q - b_q;
         3'b010:  alu_result = a_q & b_q;
         3'b011:  alu_result = a_q | b_q;
         3'b100:  alu_result = a_q ^ b_q;
         default: alu_err    = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         a_q        <= '0;
         b_q        <= '0;
         op_q       <= '0;
         id_q       <= 1'b0;
         result_q   <= '0;
         zero_q     <= 1'b0;
         err_q      <= 1'b0;
         valid_q    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (any_valid) begin
                  a_q        <= grant ? bus.req1_a  : bus.req0_a;
                  b_q        <= grant ? bus.req1_b  : bus.req0_b;
                  op_q       <= grant ? bus.req1_op : bus.req0_op;
                  id_q       <= grant;
                  last_grant <= grant;
                  state      <= EXEC;
               end
            end
            EXEC: begin
               result_q <= alu_result;
               zero_q   <= (alu_result == '0);
               err_q    <= alu_err;
               valid_q  <= 1'b1;
               state    <= RESP;
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  valid_q <= 1'b0;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // id_q only changes on acceptance in IDLE, so it doubles as the stable response id.
   assign bus.rsp_valid  = valid_q;
   assign bus.rsp_id     = id_q;
   assign bus.rsp_result = result_q;
   assign bus.rsp_zero   = zero_q;
   assign bus.rsp_err    = err_q;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: WIDTH, 4, operand/result width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req0_valid  input  1  requester 0 has a command.
REQ-005 req0_ready  output  1  requester 0 command accepted this cycle.
REQ-006 req0_a, req0_b  input  WIDTH each  requester 0 operands.
REQ-007 req0_op  input  3  requester 0 op code.
REQ-008 req1_valid, req1_ready, req1_a, req1_b, req1_op: same as REQ-004..007 for requester 1.
REQ-009 rsp_valid  output  1  response available.
REQ-010 rsp_ready  input  1  consumer accepts response.
REQ-011 rsp_id  output  1  requester that issued the command.
REQ-012 rsp_result  output  WIDTH  operation result.
REQ-013 rsp_zero  output  1  rsp_result == 0.
REQ-014 rsp_err  output  1  op code was undefined.

Function
REQ-015 FSM states SHALL be IDLE, EXEC, RESP; exactly one transaction in flight.
REQ-016 IDLE: if any reqN_valid, grant one requester, assert its reqN_ready combinationally that cycle, capture a/b/op/id, go EXEC; else stay IDLE.
REQ-017 reqN_ready SHALL be 1 only in IDLE, only for the granted requester, only when that reqN_valid=1; never both high.
REQ-018 Arbitration: single valid wins; both valid -> grant requester not granted last (round-robin); last-grant pointer updates only on acceptance.
REQ-019 EXEC: compute and register result, zero and err; go RESP next cycle unconditionally.
REQ-020 Ops: 000 a+b, 001 a-b, 010 a&b, 011 a|b, 100 a^b; add/sub modulo 2^WIDTH, carry/borrow discarded.
REQ-021 Ops 101..111: result 0, rsp_zero=1, rsp_err=1; err=0 for defined ops.
REQ-022 RESP: rsp_valid=1; rsp_id/result/zero/err SHALL hold stable while rsp_valid=1 and rsp_ready=0.
REQ-023 RESP with rsp_ready=1: response consumed that cycle, next state IDLE; rsp_valid=0 in IDLE and EXEC.
REQ-024 Latency: command accepted at cycle T -> rsp_valid first high at T+2; minimum 3 cycles per transaction.
REQ-025 Requester inputs SHALL be ignored outside the IDLE acceptance cycle; changes in EXEC/RESP do not affect captured command.
REQ-026 A requester holding valid while not granted SHALL keep ready=0 and be served in a later IDLE cycle (no starvation: served within 2 transactions).

Reset
REQ-027 rst=1 at a rising edge SHALL force IDLE, last-grant pointer=1 (requester 0 wins first tie), rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0, rsp_err=0.
REQ-028 While rst=1, req0_ready and req1_ready SHALL be 0.
REQ-029 rst asserted in EXEC or RESP SHALL discard the in-flight transaction; no response emitted for it.

Verification
REQ-030 Single: req0 a=3,b=4,op=000 in IDLE, rsp_ready=1 -> req0_ready at T, rsp_valid at T+2, result=7, id=0, zero=0, err=0.
REQ-031 Wrap/zero: req1 a=2,b=3,op=001 -> result=15, id=1; a=9,b=7,op=000 -> result=0, zero=1.
REQ-032 Fairness: both valid continuously after reset, rsp_ready=1 -> grants 0,1,0,1; each grant 3 cycles apart.
REQ-033 Backpressure: rsp_ready=0 for 5 cycles in RESP with req0 changing inputs -> rsp outputs stable, no ready asserted, IDLE one cycle after rsp_ready=1.
REQ-034 Illegal op: op=110, a=5,b=5 -> result=0, zero=1, err=1.
REQ-035 Reset mid-op: rst=1 during EXEC -> next cycle IDLE, rsp_valid stays 0, next tie granted to requester 0.
